// File: rtl/dna_mem_pkg.sv
// dna_mem_pkg: shared definitions for the DNA alignment memory sequencer.
//   state_e   - sequencer FSM states
//   DEPTH     - words per memory for the default 512-byte memory
//   CNT_W     - width of a word count that can hold DEPTH itself
//   byte_addr - word index to byte address (word aligned)
package dna_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_READ,
    ST_LOAD_REF,
    ST_FETCH,
    ST_DONE
  } state_e;

  localparam int MEM_SIZE_DEF = 512;
  localparam int DEPTH        = MEM_SIZE_DEF / 4;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  function automatic logic [31:0] byte_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/dna_pair_reg.sv
// dna_pair_reg: output register of the pair channel with valid/ready hold.
//   ld_i        - load a new pair (caller guarantees !valid_o || ready_i)
//   ready_i     - downstream ready; drops valid_o when nothing new is loaded
//   rd_i/rf_i   - read / ref word of the pair
//   row_last_i  - pair carries the last read word of its ref row
//   last_i      - final pair of the job
//   *_o         - registered copies, stable while valid_o && !ready_i
module dna_pair_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_i,
  input  logic          ready_i,
  input  logic [DW-1:0] rd_i,
  input  logic [DW-1:0] rf_i,
  input  logic          row_last_i,
  input  logic          last_i,
  output logic          valid_o,
  output logic [DW-1:0] rd_o,
  output logic [DW-1:0] rf_o,
  output logic          row_last_o,
  output logic          last_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      rd_o       <= '0;
      rf_o       <= '0;
      row_last_o <= 1'b0;
      last_o     <= 1'b0;
    end else if (ld_i) begin
      valid_o    <= 1'b1;
      rd_o       <= rd_i;
      rf_o       <= rf_i;
      row_last_o <= row_last_i;
      last_o     <= last_i;
    end else if (ready_i) begin
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: rtl/dna_mem_seq.sv
// dna_mem_seq: load-and-fetch sequencer for the DNA alignment memories.
//   start                      - job start pulse (honoured in IDLE/DONE)
//   s_valid/s_ready/s_data/s_last - host stream: packet 1 -> read mem, packet 2 -> ref mem
//   we_*/addw_*/din_*/addr_*   - memory ports (write and combinational read)
//   dout_*                     - memory read data, valid in the same cycle
//   f_valid/f_ready/f_read/f_ref/f_row_last/f_last - pair channel, ref-outer, read-inner
//   len_read/len_ref           - stored word counts (capped at DEPTH)
//   busy/done/err_ovf          - status; err_ovf is sticky until the next start
module dna_mem_seq
  import dna_mem_pkg::*;
#(
  parameter int MEM_SIZE   = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int D  = MEM_SIZE / 4,
  localparam int CW = $clog2(D) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  we_read,
  output logic [ADDR_WIDTH-1:0] addw_read,
  output logic [DATA_WIDTH-1:0] din_read,
  output logic [ADDR_WIDTH-1:0] addr_read,
  input  logic [DATA_WIDTH-1:0] dout_read,
  output logic                  we_ref,
  output logic [ADDR_WIDTH-1:0] addw_ref,
  output logic [DATA_WIDTH-1:0] din_ref,
  output logic [ADDR_WIDTH-1:0] addr_ref,
  input  logic [DATA_WIDTH-1:0] dout_ref,
  output logic                  f_valid,
  input  logic                  f_ready,
  output logic [DATA_WIDTH-1:0] f_read,
  output logic [DATA_WIDTH-1:0] f_ref,
  output logic                  f_row_last,
  output logic                  f_last,
  output logic [CW-1:0]         len_read,
  output logic [CW-1:0]         len_ref,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf
);

  state_e        state_q;
  logic [CW-1:0] len_read_q, len_ref_q;
  logic [CW-1:0] i_q, j_q;
  logic          err_q;
  logic          all_ld_q;   // final pair already loaded into the output register

  logic in_lr, in_lf, in_f, beat;
  logic room_rd, room_rf;
  logic ld, row_last, last, acc_last;

  assign in_lr = (state_q == ST_LOAD_READ);
  assign in_lf = (state_q == ST_LOAD_REF);
  assign in_f  = (state_q == ST_FETCH);

  // Load side: the stored length doubles as the next write index, so once
  // it reaches D every further beat is accepted but dropped.
  assign s_ready = in_lr | in_lf;
  assign beat    = s_valid & s_ready;
  assign room_rd = (len_read_q < CW'(D));
  assign room_rf = (len_ref_q  < CW'(D));

  assign we_read   = beat & in_lr & room_rd;
  assign addw_read = in_lr ? ADDR_WIDTH'(byte_addr(32'(len_read_q))) : '0;
  assign din_read  = in_lr ? s_data : '0;
  assign we_ref    = beat & in_lf & room_rf;
  assign addw_ref  = in_lf ? ADDR_WIDTH'(byte_addr(32'(len_ref_q))) : '0;
  assign din_ref   = in_lf ? s_data : '0;

  // Fetch side: combinational memory read at the current (i, j).
  assign addr_read = in_f ? ADDR_WIDTH'(byte_addr(32'(i_q))) : '0;
  assign addr_ref  = in_f ? ADDR_WIDTH'(byte_addr(32'(j_q))) : '0;

  assign row_last = (i_q == len_read_q - CW'(1));
  assign last     = row_last & (j_q == len_ref_q - CW'(1));
  assign ld       = in_f & ~all_ld_q & (~f_valid | f_ready);
  assign acc_last = f_valid & f_ready & f_last;

  assign busy     = in_lr | in_lf | in_f;
  assign done     = (state_q == ST_DONE);
  assign err_ovf  = err_q;
  assign len_read = len_read_q;
  assign len_ref  = len_ref_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_read_q <= '0;
      len_ref_q  <= '0;
      i_q        <= '0;
      j_q        <= '0;
      err_q      <= 1'b0;
      all_ld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_LOAD_READ;
            len_read_q <= '0;
            len_ref_q  <= '0;
            i_q        <= '0;
            j_q        <= '0;
            err_q      <= 1'b0;
            all_ld_q   <= 1'b0;
          end
        end
        ST_LOAD_READ: begin
          if (beat) begin
            if (room_rd) len_read_q <= len_read_q + CW'(1);
            else         err_q      <= 1'b1;
            if (s_last)  state_q    <= ST_LOAD_REF;
          end
        end
        ST_LOAD_REF: begin
          if (beat) begin
            if (room_rf) len_ref_q <= len_ref_q + CW'(1);
            else         err_q     <= 1'b1;
            if (s_last)  state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (ld) begin
            if (row_last) begin
              i_q <= '0;
              j_q <= j_q + CW'(1);
            end else begin
              i_q <= i_q + CW'(1);
            end
            if (last) all_ld_q <= 1'b1;
          end
          if (acc_last) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dna_pair_reg #(.DW(DATA_WIDTH)) u_pair (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_i       (ld),
    .ready_i    (f_ready),
    .rd_i       (dout_read),
    .rf_i       (dout_ref),
    .row_last_i (row_last),
    .last_i     (last),
    .valid_o    (f_valid),
    .rd_o       (f_read),
    .rf_o       (f_ref),
    .row_last_o (f_row_last),
    .last_o     (f_last)
  );

endmodule

// File: tb/tb_dna_mem_seq.sv
// tb_dna_mem_seq: directed bench for dna_mem_seq with behavioural memories.
module tb_dna_mem_seq;
  localparam int AW = 32, DW = 32, DEPTH = 128, CW = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, f_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, we_read, we_ref, f_valid, f_row_last, f_last, busy, done, err_ovf;
  logic [AW-1:0] addw_read, addr_read, addw_ref, addr_ref;
  logic [DW-1:0] din_read, din_ref, dout_read, dout_ref, f_read, f_ref;
  logic [CW-1:0] len_read, len_ref;

  logic [DW-1:0] mem_rd [DEPTH];
  logic [DW-1:0] mem_rf [DEPTH];

  int tests = 0, fails = 0;
  int wexp_r = 0, wexp_f = 0;
  logic [31:0] q_rd [$];
  logic [31:0] q_rf [$];
  bit q_rl [$];
  bit q_l [$];
  bit hold_v = 0, pend_last = 0;
  logic [31:0] h_rd, h_rf;
  logic [1:0] h_fl;

  always #5 clk = ~clk;

  dna_mem_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .we_read(we_read), .addw_read(addw_read), .din_read(din_read),
    .addr_read(addr_read), .dout_read(dout_read),
    .we_ref(we_ref), .addw_ref(addw_ref), .din_ref(din_ref),
    .addr_ref(addr_ref), .dout_ref(dout_ref),
    .f_valid(f_valid), .f_ready(f_ready), .f_read(f_read), .f_ref(f_ref),
    .f_row_last(f_row_last), .f_last(f_last),
    .len_read(len_read), .len_ref(len_ref),
    .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  assign dout_read = mem_rd[addr_read[8:2]];
  assign dout_ref  = mem_rf[addr_ref[8:2]];

  always @(posedge clk) begin
    if (we_read) mem_rd[addw_read[8:2]] <= din_read;
    if (we_ref)  mem_rf[addw_ref[8:2]]  <= din_ref;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: addresses must be contiguous and writes only on accepted beats.
  always @(negedge clk) begin
    if (we_read) begin
      chk("wr_read_addr", addw_read, 32'(wexp_r * 4));
      chk("wr_read_data", din_read, s_data);
      chk("wr_read_beat", 32'(s_valid & s_ready), 32'd1);
      wexp_r++;
    end
    if (we_ref) begin
      chk("wr_ref_addr", addw_ref, 32'(wexp_f * 4));
      chk("wr_ref_data", din_ref, s_data);
      chk("wr_ref_beat", 32'(s_valid & s_ready), 32'd1);
      wexp_f++;
    end
  end

  // Pair monitor: collect accepted pairs, check hold under stall, done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v    = 0;
      pend_last = 0;
    end else begin
      if (hold_v) begin
        chk("hold_read", f_read, h_rd);
        chk("hold_ref", f_ref, h_rf);
        chk("hold_flags", {29'd0, f_valid, f_row_last, f_last}, {29'd0, 1'b1, h_fl});
      end
      if (pend_last) begin
        chk("done_after_last", 32'(done), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
      end else if (f_valid) begin
        chk("done_early", 32'(done), 32'd0);
      end
      hold_v    = f_valid && !f_ready;
      h_rd      = f_read;
      h_rf      = f_ref;
      h_fl      = {f_row_last, f_last};
      pend_last = f_valid && f_ready && f_last;
      if (f_valid && f_ready) begin
        q_rd.push_back(f_read);
        q_rf.push_back(f_ref);
        q_rl.push_back(f_row_last);
        q_l.push_back(f_last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    wexp_r = 0;
    wexp_f = 0;
    q_rd.delete(); q_rf.delete(); q_rl.delete(); q_l.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] base, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 2 == 1)) begin
        s_valid = 1'b0;
        step();
      end
      s_valid = 1'b1;
      s_data  = base + 32'(k);
      s_last  = (k == n - 1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_fetch(input bit toggle);
    for (int c = 0; c < 2000; c++) begin
      if (done) break;
      f_ready = toggle ? (c % 2 == 0) : 1'b1;
      step();
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic verify(input int nr, input int nf, input logic [31:0] br, input logic [31:0] bf);
    chk("pair_count", 32'(q_rd.size()), 32'(nr * nf));
    for (int j = 0; j < nf; j++)
      for (int i = 0; i < nr; i++) begin
        int n;
        n = j * nr + i;
        if (n < q_rd.size()) begin
          chk("pair_read", q_rd[n], br + 32'(i));
          chk("pair_ref", q_rf[n], bf + 32'(j));
          chk("pair_row_last", 32'(q_rl[n]), 32'(i == nr - 1));
          chk("pair_last", 32'(q_l[n]), 32'((i == nr - 1) && (j == nf - 1)));
        end
      end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_we", 32'({we_read, we_ref}), 32'd0);
    chk("rst_f_flags", 32'({f_valid, f_row_last, f_last}), 32'd0);
    chk("rst_status", 32'({busy, done, err_ovf}), 32'd0);
    chk("rst_addr", addw_read | addr_read | addw_ref | addr_ref, 32'd0);
    chk("rst_data", din_read | din_ref | f_read | f_ref, 32'd0);
    chk("rst_len", 32'({len_read, len_ref}), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Job A: 4x3, always ready
    pulse_start();
    chk("a_busy_load", 32'(busy), 32'd1);
    send(32'hA000_0000, 4, 0);
    send(32'hB000_0000, 3, 0);
    chk("a_fetch_lat0", 32'(f_valid), 32'd0);
    f_ready = 1'b1;
    step();
    chk("a_fetch_lat1", 32'(f_valid), 32'd1);
    run_fetch(0);
    verify(4, 3, 32'hA000_0000, 32'hB000_0000);
    chk("a_len_read", 32'(len_read), 32'd4);
    chk("a_len_ref", 32'(len_ref), 32'd3);
    chk("a_err", 32'(err_ovf), 32'd0);

    // Job B: 4x3, stream gaps, toggling ready
    pulse_start();
    chk("b_done_drops", 32'(done), 32'd0);
    send(32'hC100_0010, 4, 1);
    send(32'hD200_0020, 3, 1);
    run_fetch(1);
    verify(4, 3, 32'hC100_0010, 32'hD200_0020);
    chk("b_writes_read", 32'(wexp_r), 32'd4);
    chk("b_writes_ref", 32'(wexp_f), 32'd3);

    // Job D: read packet overflow (130 words)
    pulse_start();
    send(32'h0000_1000, 130, 0);
    chk("d_err_ovf", 32'(err_ovf), 32'd1);
    chk("d_len_read", 32'(len_read), 32'd128);
    chk("d_writes_read", 32'(wexp_r), 32'd128);
    chk("d_in_load_ref", 32'(s_ready & busy), 32'd1);
    send(32'h0000_2000, 2, 0);
    chk("d_len_ref", 32'(len_ref), 32'd2);
    run_fetch(0);
    verify(128, 2, 32'h0000_1000, 32'h0000_2000);
    chk("d_err_sticky", 32'(err_ovf), 32'd1);

    // Job E: start ignored during fetch, then async reset mid-fetch
    pulse_start();
    chk("e_err_cleared", 32'(err_ovf), 32'd0);
    send(32'hE000_0000, 4, 0);
    send(32'hF000_0000, 3, 0);
    f_ready = 1'b1;
    step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("e_start_ignored_busy", 32'(busy), 32'd1);
    chk("e_start_ignored_len", 32'(len_read), 32'd4);
    chk("e_start_ignored_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("e_rst_f_valid", 32'(f_valid), 32'd0);
    chk("e_rst_busy", 32'(busy), 32'd0);
    chk("e_rst_len", 32'({len_read, len_ref}), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("e_idle_status", 32'({busy, done, s_ready}), 32'd0);

    // Job C: 1x1 after reset
    pulse_start();
    send(32'h1234_5678, 1, 0);
    send(32'h9ABC_DEF0, 1, 0);
    run_fetch(0);
    verify(1, 1, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("c_len", 32'({len_read, len_ref}), 32'h0101);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dna_mem_seq.md
# dna_mem_seq

Load-and-fetch sequencer for the DNA alignment memory subsystem. It fills the read-sequence and reference-sequence memories from a single host word stream, then scans both memories in nested order. It delivers every (read word, reference word) pair to the alignment datapath over a valid/ready channel. It drives the `read` and `ref` port groups of the memory top; the 16 matrix banks are outside its scope.

## Interface
- `MEM_SIZE`, 512: bytes per memory; depth `DEPTH = MEM_SIZE/4` words (128).
- `ADDR_WIDTH`, 32: memory address width; addresses are byte addresses, word-aligned (bits [1:0] always 0).
- `DATA_WIDTH`, 32: word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a load+fetch job; honoured only in IDLE or DONE.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in DATA_WIDTH / `s_last` in 1: host load stream. The first packet goes to the read memory and the second to the ref memory; `s_last` marks the final word of each packet.
- `we_read`, `addw_read`, `din_read`, `addr_read` out 1/ADDR_WIDTH/DATA_WIDTH/ADDR_WIDTH: read-memory port.
- `dout_read` in DATA_WIDTH: read-memory data.
- `we_ref`, `addw_ref`, `din_ref`, `addr_ref`, `dout_ref`: same for the ref memory.
- `f_valid` out 1 / `f_ready` in 1: pair channel to the datapath.
- `f_read` out DATA_WIDTH / `f_ref` out DATA_WIDTH: pair payload.
- `f_row_last` out 1: the pair carries the last read word of the current ref row.
- `f_last` out 1: final pair of the job.
- `len_read`, `len_ref` out $clog2(DEPTH)+1: stored word counts.
- `busy` out 1 / `done` out 1 / `err_ovf` out 1: status.

## Operation
- States: IDLE, LOAD_READ, LOAD_REF, FETCH, DONE.
- IDLE/DONE + `start`: go to LOAD_READ. This clears `len_read`, `len_ref` and `err_ovf`; `done` drops.
- LOAD_*: `s_ready`=1.
  - Each beat (`s_valid`&&`s_ready`) with index k < DEPTH drives, combinationally in the same cycle, `we_x`=1, `addw_x`=k*4, `din_x`=`s_data`, and increments `len_x`.
  - A beat with k ≥ DEPTH is accepted and dropped: no write, `err_ovf` set (sticky until the next `start`).
  - A beat with `s_last` moves LOAD_READ to LOAD_REF, and LOAD_REF to FETCH.
  - A packet always holds at least 1 word.
- FETCH: counters j (ref index, outer) and i (read index, inner).
  - Combinational outputs: `addr_ref`=j*4, `addr_read`=i*4.
  - Memory read is combinational, so `dout_*` is valid in the same cycle.
  - The output register loads {`dout_read`, `dout_ref`, `f_row_last`=(i==len_read-1), `f_last`=(row_last && j==len_ref-1)} whenever `!f_valid || f_ready`, then advances i. When i wraps to 0, j increments.
  - After the last pair is loaded, no more pairs are loaded. The block enters DONE in the cycle the `f_last` pair is accepted.
- DONE: `done`=1 and `busy`=0. `start` in DONE starts a new job; the old memory contents are overwritten.
- `start` while busy is ignored.
- `we_*`=0 outside the LOAD states. Each memory is written only in its own LOAD state.

## Timing
- Reset values: state IDLE; `s_ready`, `we_*`, `f_valid`, `f_row_last`, `f_last`, `busy`, `done`, `err_ovf` = 0; all address, data and len outputs = 0.
- `busy`=1 in LOAD_READ, LOAD_REF and FETCH.
- Load: one word per cycle at full throughput. The write occurs on the accept edge.
- Fetch latency: first `f_valid` one cycle after entering FETCH. Throughput is 1 pair/cycle while `f_ready`=1.
- Backpressure: while `f_valid`&&!`f_ready`, the payload, `f_row_last` and `f_last` are held stable, and i and j freeze.
- Pair count is exactly `len_read`*`len_ref`, with `len_x` capped at DEPTH.
- Length 1: `f_row_last`=1 on every pair when `len_read`=1; `f_last` on the final pair.
- An async reset mid-job returns the block to IDLE immediately. Memory contents are not cleared, and the lengths are zeroed.

## Structure
- Shared package `dna_mem_pkg` holds:
  - the state enum;
  - the `DEPTH` and `CNT_W` localparam formulas;
  - the byte-address helper (`idx<<2`).
- One sub-module, `dna_pair_reg`, implements the FETCH output register with valid/ready hold.

## Test plan
- Load read {A0..A3} and ref {B0..B2}, `f_ready`=1 → 12 pairs in order (A0,B0),(A1,B0)…(A3,B2); `f_row_last` on i=3; `f_last` only on (A3,B2); `done` one cycle after the last accept; `len_read`=4, `len_ref`=3.
- Same job with `f_ready` toggling 1/0 every cycle → identical pair sequence; the payload is stable during every stall; no pair is duplicated or lost.
- Read packet of 130 words (DEPTH=128) → `err_ovf`=1; `len_read`=128; no write for beats 128 and 129; LOAD_REF follows.
- Single-word packets (1×1) → exactly one pair with `f_row_last`=`f_last`=1.
- `start` pulsed during FETCH → ignored; assert `rst_n`=0 mid-FETCH → `f_valid`, `busy`, `len_*` = 0 asynchronously; after release the block is in IDLE.
- `s_valid` gaps during load → addresses 0,4,8,… stay contiguous; `we_*` is asserted only on accepted beats.
